// File: rtl/tilelink_ram_pkg.sv
// ---------------------------------------------------------------------------
// tilelink_ram_pkg
// Shared TileLink-UL definitions for the tilelink_ram slave: A/D channel
// structs, request/response opcodes, the largest legal transfer size and the
// byte-lane merge helper used to build write responses.
// Contents:
//   tilelink_a  - A channel (valid, opcode, size, source, address, mask, data)
//   tilelink_d  - D channel; d_ready carries the slave's A-channel ready
//   data_sel_e  - selects what a pending response returns on d_data
//   laneMerge() - per-byte select between an old word and new write data
// ---------------------------------------------------------------------------
package tilelink_ram_pkg;

  // A-channel request opcodes
  localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_ARITHMETIC_DATA  = 3'd2;
  localparam logic [2:0] TL_LOGICAL_DATA     = 3'd3;
  localparam logic [2:0] TL_GET              = 3'd4;
  localparam logic [2:0] TL_INTENT           = 3'd5;

  // D-channel response opcodes
  localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'd1;

  // Largest a_size this 32-bit slave serves (2^2 = 4 bytes)
  localparam logic [2:0] TL_MAX_SIZE         = 3'd2;

  localparam int TL_SOURCE_W = 8;

  typedef struct packed {
    logic                   a_valid;
    logic [2:0]             a_opcode;
    logic [2:0]             a_size;
    logic [TL_SOURCE_W-1:0] a_source;
    logic [31:0]            a_address;
    logic [3:0]             a_mask;
    logic [31:0]            a_data;
  } tilelink_a;

  typedef struct packed {
    logic                   d_valid;
    logic [2:0]             d_opcode;
    logic [1:0]             d_param;
    logic [2:0]             d_size;
    logic [TL_SOURCE_W-1:0] d_source;
    logic                   d_sink;
    logic [31:0]            d_data;
    logic                   d_error;
    logic                   d_ready;
  } tilelink_d;

  typedef enum logic [1:0] {
    DSEL_ZERO,
    DSEL_READ,
    DSEL_MERGE
  } data_sel_e;

  // Byte lane b takes newWord when mask[b] is set, otherwise keeps oldWord
  function automatic logic [31:0] laneMerge(input logic [31:0] oldWord,
                                            input logic [31:0] newWord,
                                            input logic [3:0]  mask);
    logic [31:0] result;
    result = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) result[8*b +: 8] = newWord[8*b +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/tilelink_ram_array.sv
// ---------------------------------------------------------------------------
// tilelink_ram_array
// Single-port synchronous word RAM with per-byte write enables and a 1-cycle
// registered read. Reads are read-first: a write cycle returns the word as it
// was before the write, which the parent uses to build merged write data.
// The read register only updates when i_en is high, so the output stays put
// while the parent is stalled. Memory contents are never touched by reset.
// Parameters: DEPTH_WORDS (32-bit words), FILENAME (image name)
// Ports:
//   clock   - system clock
//   i_en    - access enable (read and/or write this cycle)
//   i_we    - byte write enables, lane i = bits [8i+7:8i]
//   i_addr  - word index
//   i_wdata - write data, already aligned to its byte lanes
//   o_rdata - registered read data
// ---------------------------------------------------------------------------
module tilelink_ram_array #(
   parameter int    DEPTH_WORDS = 16384,
   parameter string FILENAME    = ""
) (
   input  logic                           clock,
   input  logic                           i_en,
   input  logic [3:0]                     i_we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
   input  logic [31:0]                    i_wdata,
   output logic [31:0]                    o_rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];
   logic [31:0] r_rdata;

   // Read-first port: old word is captured before the byte writes land
   always_ff @(posedge clock) begin
      if (i_en) begin
         r_rdata <= r_mem[i_addr];
         for (int b = 0; b < 4; b++) begin
            if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/tilelink_ram.sv
// ---------------------------------------------------------------------------
// tilelink_ram
// TileLink-UL slave RAM: decodes Get/PutFullData/PutPartialData against a
// window of DEPTH_WORDS words at BASE_ADDR, merges partial writes, flags
// out-of-range / oversize / unsupported requests as errors, and returns one
// AccessAck(Data) per request with D-channel backpressure.
// Parameters: DEPTH_WORDS, BASE_ADDR (aligned to DEPTH_WORDS*4), FILENAME
// Ports:
//   clock   - system clock
//   reset   - synchronous, active-high
//   tla     - A channel request
//   d_ready - downstream accepts the current D beat
//   tld     - D channel response; tld.d_ready is this block's a_ready
// Build option: TILELINK_RAM_OUTREG_EN adds a 2-entry registered response
// FIFO after the response stage (latency 2 instead of 1, same throughput).
// ---------------------------------------------------------------------------
module tilelink_ram
  import tilelink_ram_pkg::*;
#(
  parameter int          DEPTH_WORDS = 16384,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter string       FILENAME    = ""
) (
  input  logic      clock,
  input  logic      reset,
  input  tilelink_a tla,
  input  logic      d_ready,
  output tilelink_d tld
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  logic                   w_aReady;
  logic                   w_accept;
  logic                   w_isGet;
  logic                   w_isPut;
  logic                   w_error;
  logic                   w_s1Advance;
  logic [31:0]            w_offset;
  logic [31:0]            w_shifted;
  logic [31:0]            w_rdata;
  logic [31:0]            w_s1Data;
  logic [AW-1:0]          w_index;
  logic [3:0]             w_we;
  tilelink_d              w_s1Resp;

  state_e                 r_state;
  logic [2:0]             r_opcode;
  logic [2:0]             r_size;
  logic [TL_SOURCE_W-1:0] r_source;
  logic                   r_error;
  data_sel_e              r_sel;
  logic [31:0]            r_shifted;
  logic [3:0]             r_mask;

  // Addresses below BASE_ADDR wrap to huge offsets and fail the range test
  assign w_offset  = tla.a_address - BASE_ADDR;
  assign w_index   = w_offset[AW+1:2];
  assign w_isGet   = (tla.a_opcode == TL_GET);
  assign w_isPut   = (tla.a_opcode == TL_PUT_FULL_DATA) ||
                     (tla.a_opcode == TL_PUT_PARTIAL_DATA);
  assign w_error   = (w_offset >= SPAN) || (tla.a_size > TL_MAX_SIZE) ||
                     !(w_isGet || w_isPut);
  assign w_shifted = tla.a_data << {tla.a_address[1:0], 3'b000};
  assign w_accept  = tla.a_valid && w_aReady;
  assign w_we      = (w_accept && w_isPut && !w_error) ? tla.a_mask : 4'b0000;

  tilelink_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .FILENAME    (FILENAME)
  ) u_array (
    .clock   (clock),
    .i_en    (w_accept),
    .i_we    (w_we),
    .i_addr  (w_index),
    .i_wdata (w_shifted),
    .o_rdata (w_rdata)
  );

  // Response stage: a new accept always reloads it, even while a beat is
  // leaving on the same edge, which gives one beat per cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_opcode  <= 3'd0;
      r_size    <= 3'd0;
      r_source  <= '0;
      r_error   <= 1'b0;
      r_sel     <= DSEL_ZERO;
      r_shifted <= 32'd0;
      r_mask    <= 4'd0;
    end else if (w_accept) begin
      r_state   <= ST_RESP;
      r_opcode  <= w_isGet ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
      r_size    <= tla.a_size;
      r_source  <= tla.a_source;
      r_error   <= w_error;
      r_sel     <= w_error ? DSEL_ZERO : (w_isGet ? DSEL_READ : DSEL_MERGE);
      r_shifted <= w_shifted;
      r_mask    <= tla.a_mask;
    end else if (r_state == ST_RESP && w_s1Advance) begin
      r_state   <= ST_IDLE;
    end
  end

  // The RAM returns the pre-write word, so a Put's response re-merges it
  always_comb begin
    unique case (r_sel)
      DSEL_READ:  w_s1Data = w_rdata;
      DSEL_MERGE: w_s1Data = laneMerge(w_rdata, r_shifted, r_mask);
      default:    w_s1Data = 32'd0;
    endcase
    w_s1Resp          = '0;
    w_s1Resp.d_valid  = (r_state == ST_RESP);
    w_s1Resp.d_opcode = r_opcode;
    w_s1Resp.d_size   = r_size;
    w_s1Resp.d_source = r_source;
    w_s1Resp.d_data   = w_s1Data;
    w_s1Resp.d_error  = r_error;
    w_s1Resp.d_ready  = w_aReady;
  end

`ifdef TILELINK_RAM_OUTREG_EN
  logic       r_rdPtr;
  logic       r_wrPtr;
  logic [1:0] r_count;
  tilelink_d  r_fifo [2];
  logic       w_push;
  logic       w_pop;
  logic [2:0] w_occupancy;

  // The response stage drains into the FIFO every cycle; a_ready reserves
  // the slot that the response in flight will need on the next edge
  assign w_s1Advance = 1'b1;
  assign w_push      = (r_state == ST_RESP);
  assign w_pop       = (r_count != 2'd0) && d_ready;
  assign w_occupancy = 3'(r_count) + 3'(w_push) - 3'(w_pop);
  assign w_aReady    = !reset && (w_occupancy < 3'd2);

  // Two-entry circular response buffer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdPtr   <= 1'b0;
      r_wrPtr   <= 1'b0;
      r_count   <= 2'd0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wrPtr] <= w_s1Resp;
        r_wrPtr         <= ~r_wrPtr;
      end
      if (w_pop) r_rdPtr <= ~r_rdPtr;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
  end

  always_comb begin
    tld         = r_fifo[r_rdPtr];
    tld.d_valid = (r_count != 2'd0);
    tld.d_ready = w_aReady;
  end
`else
  assign w_s1Advance = d_ready;
  assign w_aReady    = !reset && ((r_state == ST_IDLE) || d_ready);
  assign tld         = w_s1Resp;
`endif

endmodule

// File: tb/tb_tilelink_ram.sv
// ---------------------------------------------------------------------------
// tb_tilelink_ram
// Self-checking bench for tilelink_ram. A behavioural model keeps the memory
// image as a plain word array and a queue of expected responses; every D beat
// is checked against the queue head in order.
// ---------------------------------------------------------------------------
module tb_tilelink_ram;
  import tilelink_ram_pkg::*;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_4000;
  localparam logic [31:0] SPAN  = 32'(DEPTH) * 32'd4;
`ifdef TILELINK_RAM_OUTREG_EN
  localparam int CAP = 2;
  localparam int LAT = 2;
`else
  localparam int CAP = 1;
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  size;
    logic [7:0]  src;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic      clock = 1'b0;
  logic      reset;
  logic      d_ready;
  tilelink_a tla;
  tilelink_d tld;

  exp_t        expQ[$];
  logic [31:0] model [DEPTH];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          beatCount = 0;
  int          acceptCount = 0;
  int          firstAccept = -1;
  int          firstFire = -1;
  logic        lastAccept = 1'b0;
  logic [31:0] lastData = 32'd0;
  logic        lastErr = 1'b0;
  logic [2:0]  lastOp = 3'd0;
  logic        stallValid = 1'b0;
  tilelink_d   stallSnap;

  always #5 clock = ~clock;

  tilelink_ram #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .FILENAME    ("")
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .tla     (tla),
    .d_ready (d_ready),
    .tld     (tld)
  );

  // Single comparison point: counts and reports
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      fails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour of one accepted request, straight from the rules
  task automatic modelAccept();
    exp_t        e;
    logic [31:0] off;
    logic [31:0] shifted;
    logic [31:0] word;
    int          idx;
    off    = tla.a_address - BASE;
    e.size = tla.a_size;
    e.src  = tla.a_source;
    e.op   = (tla.a_opcode == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
    e.err  = (off >= SPAN) || (tla.a_size > 3'd2) ||
             !(tla.a_opcode inside {TL_GET, TL_PUT_FULL_DATA, TL_PUT_PARTIAL_DATA});
    e.data = 32'd0;
    if (!e.err) begin
      idx  = int'(off >> 2);
      word = model[idx];
      if (tla.a_opcode != TL_GET) begin
        shifted = tla.a_data << (8 * tla.a_address[1:0]);
        for (int b = 0; b < 4; b++) begin
          if (tla.a_mask[b]) word[8*b +: 8] = shifted[8*b +: 8];
        end
        model[idx] = word;
      end
      e.data = word;
    end
    expQ.push_back(e);
  endtask

  // One clock: sample mid low-phase, score beats, model accepts, advance
  task automatic stepCycle();
    logic      fire;
    logic      accept;
    exp_t      e;
    tilelink_d cur;
    #1;
    fire   = tld.d_valid && d_ready;
    accept = tla.a_valid && tld.d_ready;
    checkOutput("a_ready", 64'(tld.d_ready), 64'((expQ.size() - (fire ? 1 : 0)) < CAP));
`ifndef TILELINK_RAM_OUTREG_EN
    checkOutput("d_valid", 64'(tld.d_valid), 64'(expQ.size() != 0));
`endif
    cur = tld;
    cur.d_ready = 1'b0;
    if (stallValid) checkOutput("hold_stable", 64'(cur), 64'(stallSnap));
    stallValid = tld.d_valid && !d_ready;
    stallSnap  = cur;
    if (fire) begin
      checkOutput("beat_expected", 64'(expQ.size() != 0), 64'd1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("beat_hdr",
          64'({tld.d_opcode, tld.d_param, tld.d_size, tld.d_source, tld.d_sink, tld.d_error}),
          64'({e.op, 2'b00, e.size, e.src, 1'b0, e.err}));
        checkOutput("beat_data", 64'(tld.d_data), 64'(e.data));
      end
      lastData = tld.d_data;
      lastErr  = tld.d_error;
      lastOp   = tld.d_opcode;
      beatCount++;
      if (firstFire < 0) firstFire = cyc;
    end
    if (accept) begin
      modelAccept();
      acceptCount++;
      if (firstAccept < 0) firstAccept = cyc;
    end
    lastAccept = accept;
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] op,
                               input logic [2:0] size, input logic [7:0] src,
                               input logic [31:0] addr, input logic [3:0] mask,
                               input logic [31:0] data, input logic dr);
    tla.a_valid   = valid;
    tla.a_opcode  = op;
    tla.a_size    = size;
    tla.a_source  = src;
    tla.a_address = addr;
    tla.a_mask    = mask;
    tla.a_data    = data;
    d_ready       = dr;
    stepCycle();
  endtask

  // Present a request with d_ready high until it is accepted (bounded)
  task automatic sendReq(input logic [2:0] op, input logic [2:0] size,
                         input logic [7:0] src, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data);
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b1, op, size, src, addr, mask, data, 1'b1);
      if (lastAccept) break;
    end
    checkOutput("req_accepted", 64'(lastAccept), 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && expQ.size() != 0; k++) begin
      applyStimulus(1'b0, 3'd0, 3'd0, 8'd0, 32'd0, 4'd0, 32'd0, 1'b1);
    end
    checkOutput("drain_empty", 64'(expQ.size()), 64'd0);
  endtask

  // One reset edge; optionally present a Put that must be ignored
  task automatic doReset(input logic withPut);
    tla = '0;
    if (withPut) begin
      tla.a_valid   = 1'b1;
      tla.a_opcode  = TL_PUT_FULL_DATA;
      tla.a_size    = 3'd2;
      tla.a_source  = 8'h22;
      tla.a_address = BASE + 32'h30;
      tla.a_mask    = 4'hF;
      tla.a_data    = 32'h0BAD_BEEF;
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    tla = '0;
    expQ.delete();
    stallValid = 1'b0;
    #1;
    checkOutput("rst_d_valid", 64'(tld.d_valid), 64'd0);
    checkOutput("rst_fields",
      64'({tld.d_opcode, tld.d_param, tld.d_size, tld.d_source, tld.d_sink, tld.d_error}), 64'd0);
    checkOutput("rst_d_data", 64'(tld.d_data), 64'd0);
    checkOutput("rst_a_ready", 64'(tld.d_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          r;
    logic [2:0]  rop;
    logic [2:0]  rsize;
    logic [31:0] raddr;
    int          acc;

    reset   = 1'b1;
    d_ready = 1'b1;
    tla     = '0;
    doReset(1'b0);

    // Known image for the whole window
    for (int i = 0; i < DEPTH; i++) begin
      sendReq(TL_PUT_FULL_DATA, 3'd2, 8'(i), BASE + 32'(i * 4), 4'hF, $urandom);
    end
    drain();

    // Put then Get
    sendReq(TL_PUT_FULL_DATA, 3'd2, 8'd3, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    sendReq(TL_GET, 3'd2, 8'd4, BASE + 32'h10, 4'h0, 32'd0);
    drain();
    checkOutput("put_get_data", 64'(lastData), 64'hDEAD_BEEF);

    // Partial write into upper half-word
    sendReq(TL_PUT_FULL_DATA, 3'd2, 8'd1, BASE + 32'h10, 4'hF, 32'h1122_3344);
    sendReq(TL_PUT_PARTIAL_DATA, 3'd1, 8'd2, BASE + 32'h12, 4'hC, 32'h0000_AABB);
    sendReq(TL_GET, 3'd2, 8'd3, BASE + 32'h10, 4'h0, 32'd0);
    drain();
    checkOutput("partial_data", 64'(lastData), 64'hAABB_3344);

    // Backpressure, then release together with a new Get
    beatCount = 0;
    acceptCount = 0;
    applyStimulus(1'b1, TL_GET, 3'd2, 8'd5, BASE + 32'h10, 4'h0, 32'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, TL_GET, 3'd2, 8'd6, BASE + 32'h20, 4'h0, 32'd0, 1'b0);
    end
    sendReq(TL_GET, 3'd2, 8'd7, BASE + 32'h24, 4'h0, 32'd0);
    drain();
    checkOutput("bp_beats", 64'(beatCount), 64'(acceptCount));

    // Error responses
    sendReq(TL_GET, 3'd2, 8'd9, BASE + SPAN, 4'h0, 32'd0);
    drain();
    checkOutput("oor_err", 64'(lastErr), 64'd1);
    checkOutput("oor_data", 64'(lastData), 64'd0);
    sendReq(TL_GET, 3'd2, 8'd10, BASE - 32'd4, 4'h0, 32'd0);
    drain();
    checkOutput("below_base_err", 64'(lastErr), 64'd1);
    sendReq(TL_PUT_FULL_DATA, 3'd3, 8'd11, BASE + 32'h10, 4'hF, 32'h5555_5555);
    drain();
    checkOutput("size3_err", 64'(lastErr), 64'd1);
    sendReq(TL_GET, 3'd2, 8'd12, BASE + 32'h10, 4'h0, 32'd0);
    drain();
    checkOutput("size3_unchanged", 64'(lastData), 64'hAABB_3344);
    sendReq(TL_ARITHMETIC_DATA, 3'd2, 8'd13, BASE + 32'h10, 4'hF, 32'h1);
    drain();
    checkOutput("arith_err", 64'(lastErr), 64'd1);
    checkOutput("arith_op", 64'(lastOp), 64'(TL_ACCESS_ACK));

    // Reset while a response is stalled
    applyStimulus(1'b1, TL_PUT_FULL_DATA, 3'd2, 8'h21, BASE + 32'h30, 4'hF, 32'hCAFE_F00D, 1'b0);
    checkOutput("rst_put_accepted", 64'(lastAccept), 64'd1);
    applyStimulus(1'b0, 3'd0, 3'd0, 8'd0, 32'd0, 4'd0, 32'd0, 1'b0);
    doReset(1'b1);
    sendReq(TL_GET, 3'd2, 8'h23, BASE + 32'h30, 4'h0, 32'd0);
    drain();
    checkOutput("rst_write_kept", 64'(lastData), 64'hCAFE_F00D);

    // Streaming Gets
    beatCount = 0;
    firstAccept = -1;
    firstFire = -1;
    acc = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, TL_GET, 3'd2, 8'(i), BASE + 32'($urandom_range(0, DEPTH - 1) * 4),
                    4'h0, 32'd0, 1'b1);
      if (lastAccept) acc++;
    end
    drain();
    checkOutput("stream_accepts", 64'(acc), 64'd64);
    checkOutput("stream_beats", 64'(beatCount), 64'd64);
    checkOutput("stream_latency", 64'(firstFire - firstAccept), 64'(LAT));

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 9);
      if (r < 4) rop = TL_GET;
      else if (r < 6) rop = TL_PUT_FULL_DATA;
      else if (r < 8) rop = TL_PUT_PARTIAL_DATA;
      else begin
        rop = 3'($urandom_range(2, 7));
        if (rop == TL_GET) rop = TL_LOGICAL_DATA;
      end
      rsize = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      raddr = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, SPAN - 1));
      applyStimulus(1'($urandom_range(0, 3) != 0), rop, rsize, 8'($urandom), raddr,
                    4'($urandom), $urandom, 1'($urandom_range(0, 9) < 7));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
